// File: rtl/green_ins_enc_if.sv
// Command and instruction-bus bundle for the green instruction encoder.
//
// master : command source / instruction sink side (drives commands and ins_stall)
// slave  : the encoder (drives cmd_ready, the instruction word and status)
//
// Signals
//   cmd_valid  command present
//   cmd_ready  command can be accepted this cycle (combinational on ins_stall)
//   cmd_op     0=load, 1=store, 2=increment, 3=no-op
//   cmd_sel    register select, 0=RA, 1=RB
//   cmd_arg    11-bit operand
//   cmd_rep    extra repeats (0 = single word)
//   ins_out    16-bit instruction word to the decoder
//   ins_valid  ins_out holds a real word
//   ins_stall  sink cannot accept the current word
//   busy       command in progress
//   issued_cnt count of words accepted by the sink
interface green_ins_enc_if #(
  parameter int unsigned REP_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_sel;
  logic [10:0]      cmd_arg;
  logic [REP_W-1:0] cmd_rep;
  logic [15:0]      ins_out;
  logic             ins_valid;
  logic             ins_stall;
  logic             busy;
  logic [15:0]      issued_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_sel,
    output cmd_arg,
    output cmd_rep,
    output ins_stall,
    input  cmd_ready,
    input  ins_out,
    input  ins_valid,
    input  busy,
    input  issued_cnt
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_sel,
    input  cmd_arg,
    input  cmd_rep,
    input  ins_stall,
    output cmd_ready,
    output ins_out,
    output ins_valid,
    output busy,
    output issued_cnt
  );

endinterface

// File: rtl/green_ins_enc.sv
// Instruction encoder/issuer for the green datapath.
//
// Accepts register commands over a valid/ready handshake and issues cmd_rep+1
// 16-bit instruction words per command to the green decoder. Store commands
// walk their address (arg) by one per issued word, wrapping at 11 bits. When no
// word is being issued the bus carries the no-op word 16'hF000.
//
// Ports
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  green_ins_enc_if.slave (command handshake, instruction bus, status)
//
// All bus outputs are functions of registered state only, except cmd_ready,
// which depends combinationally on ins_stall so a follow-on command can be
// taken in the same cycle the final word of the current one is consumed.
module green_ins_enc #(
  parameter int unsigned REP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  green_ins_enc_if.slave  bus
);

  localparam logic [1:0]  OpLoad  = 2'd0;
  localparam logic [1:0]  OpStore = 2'd1;
  localparam logic [1:0]  OpInc   = 2'd2;
  localparam logic [1:0]  OpNop   = 2'd3;
  localparam logic [15:0] IdleWord = 16'hF000;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sel_q, sel_d;
  logic [10:0]      arg_q, arg_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             last;
  logic             consume;
  logic             accept;
  logic             cmd_ready;
  logic [3:0]       opcode;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    arg_d   = arg_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;

    last      = (rem_q == '0);
    // ins_stall only matters while a word is actually presented.
    consume   = (state_q == StIssue) && !bus.ins_stall;
    cmd_ready = (state_q == StIdle) || (consume && last);
    accept    = bus.cmd_valid && cmd_ready;

    if (consume) begin
      cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = bus.cmd_op;
          sel_d   = bus.cmd_sel;
          arg_d   = bus.cmd_arg;
          rem_d   = bus.cmd_rep;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (consume && !last) begin
          rem_d = rem_q - {{(REP_W-1){1'b0}}, 1'b1};
          if (op_q == OpStore) begin
            arg_d = arg_q + 11'd1;
          end
        end else if (accept) begin
          // Back-to-back: final word consumed and the next command taken in
          // the same cycle, so its first word follows with no idle gap.
          op_d    = bus.cmd_op;
          sel_d   = bus.cmd_sel;
          arg_d   = bus.cmd_arg;
          rem_d   = bus.cmd_rep;
          state_d = StIssue;
        end else if (consume) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; reset discards any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      sel_q   <= 1'b0;
      arg_q   <= 11'd0;
      rem_q   <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word encoding and status outputs.
  always_comb begin
    opcode = 4'b1111;
    unique case (op_q)
      OpLoad:  opcode = 4'b0000;
      OpStore: opcode = 4'b0001;
      OpInc:   opcode = 4'b0010;
      OpNop:   opcode = 4'b1111;
      default: opcode = 4'b1111;
    endcase

    bus.cmd_ready  = cmd_ready;
    bus.ins_valid  = (state_q == StIssue);
    bus.busy       = (state_q == StIssue);
    bus.issued_cnt = cnt_q;
    bus.ins_out    = (state_q == StIssue) ? {opcode, sel_q, arg_q} : IdleWord;
  end

endmodule

// File: tb/tb_green_ins_enc.sv
// Self-checking bench for green_ins_enc: directed scenarios followed by random
// traffic, all compared each cycle against a queue-of-expected-words model.
module tb_green_ins_enc;

  localparam int unsigned RepW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  green_ins_enc_if #(.REP_W(RepW)) bus ();

  green_ins_enc #(.REP_W(RepW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words still to be issued, in order, plus the consumed-word count.
  logic [15:0] exp_q[$];
  logic [15:0] mdl_cnt;

  // Last observed outputs, for directed checks after a step.
  logic [15:0] obs_out;
  logic        obs_valid;
  logic        obs_ready;
  logic        obs_busy;
  logic [15:0] obs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [1:0] op, input logic sel,
                                      input logic [10:0] arg);
    logic [3:0] opc;
    opc = (op == 2'd3) ? 4'hF : {2'b00, op};
    return {opc, sel, arg};
  endfunction

  // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
  task automatic step(input logic r, input logic v, input logic [1:0] op, input logic sel,
                      input logic [10:0] arg, input logic [RepW-1:0] rep,
                      input logic stall);
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_out;
    rst           = r;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    bus.cmd_arg   = arg;
    bus.cmd_rep   = rep;
    bus.ins_stall = stall;
    @(negedge clk);
    m_valid = (exp_q.size() != 0);
    m_out   = m_valid ? exp_q[0] : 16'hF000;
    m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && !stall);
    obs_out   = bus.ins_out;
    obs_valid = bus.ins_valid;
    obs_ready = bus.cmd_ready;
    obs_busy  = bus.busy;
    obs_cnt   = bus.issued_cnt;
    check_eq("ins_out", obs_out, m_out);
    check_eq("ins_valid", obs_valid, m_valid);
    check_eq("cmd_ready", obs_ready, m_ready);
    check_eq("busy", obs_busy, m_valid);
    check_eq("issued_cnt", obs_cnt, mdl_cnt);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      mdl_cnt = 16'd0;
    end else begin
      if (m_valid && !stall) begin
        void'(exp_q.pop_front());
        mdl_cnt = mdl_cnt + 16'd1;
      end
      if (v && m_ready) begin
        for (int i = 0; i <= int'(rep); i++) begin
          exp_q.push_back(enc(op, sel, (op == 2'd1) ? arg + 11'(i) : arg));
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic stall);
    step(1'b0, 1'b0, 2'd0, 1'b0, 11'd0, '0, stall);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_sel   = 1'b0;
    bus.cmd_arg   = 11'd0;
    bus.cmd_rep   = '0;
    bus.ins_stall = 1'b0;
    mdl_cnt       = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check_eq("rst_ins_out", bus.ins_out, 16'hF000);
    check_eq("rst_ins_valid", bus.ins_valid, 1'b0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_issued_cnt", bus.issued_cnt, 16'd0);
    @(posedge clk);
    #1;

    // Single load RA 0x123.
    step(1'b0, 1'b1, 2'd0, 1'b0, 11'h123, '0, 1'b0);
    idle(1'b0);
    check_eq("load_word", obs_out, 16'h0123);
    check_eq("load_valid", obs_valid, 1'b1);
    idle(1'b0);
    check_eq("load_after", obs_out, 16'hF000);
    check_eq("load_cnt", obs_cnt, 16'd1);
    check_eq("load_ready", obs_ready, 1'b1);

    // Increment RB, four words.
    step(1'b0, 1'b1, 2'd2, 1'b1, 11'd0, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check_eq("inc_word", obs_out, 16'h2800);
      check_eq("inc_busy", obs_busy, 1'b1);
    end
    idle(1'b0);
    check_eq("inc_busy_done", obs_busy, 1'b0);
    check_eq("inc_cnt", obs_cnt, 16'd5);  // 1 from the load + 4

    // Store walking across the 11-bit wrap, stalled on the second word.
    step(1'b0, 1'b1, 2'd1, 1'b0, 11'h7FE, 4'd2, 1'b0);
    idle(1'b0);
    check_eq("st_w0", obs_out, 16'h17FE);
    idle(1'b1);
    check_eq("st_w1_stall0", obs_out, 16'h17FF);
    check_eq("st_ready_stall", obs_ready, 1'b0);
    idle(1'b1);
    check_eq("st_w1_stall1", obs_out, 16'h17FF);
    idle(1'b0);
    check_eq("st_w1_go", obs_out, 16'h17FF);
    check_eq("st_ready_mid", obs_ready, 1'b0);
    idle(1'b0);
    check_eq("st_w2", obs_out, 16'h1000);
    check_eq("st_ready_last", obs_ready, 1'b1);
    idle(1'b0);
    check_eq("st_cnt", obs_cnt, 16'd8);

    // Back-to-back: load RB 0x005 then inc RA 0.
    step(1'b0, 1'b1, 2'd0, 1'b1, 11'h005, '0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0, 11'h000, '0, 1'b0);
    check_eq("b2b_first", obs_out, 16'h0805);
    check_eq("b2b_ready", obs_ready, 1'b1);
    idle(1'b0);
    check_eq("b2b_second", obs_out, 16'h2000);
    check_eq("b2b_valid", obs_valid, 1'b1);
    idle(1'b0);
    check_eq("b2b_idle", obs_out, 16'hF000);

    // Reset in the middle of a long no-op command.
    step(1'b0, 1'b1, 2'd3, 1'b0, 11'd0, 4'd7, 1'b0);
    repeat (3) idle(1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 11'd0, '0, 1'b0);
    idle(1'b0);
    check_eq("mid_rst_out", obs_out, 16'hF000);
    check_eq("mid_rst_valid", obs_valid, 1'b0);
    check_eq("mid_rst_busy", obs_busy, 1'b0);
    check_eq("mid_rst_cnt", obs_cnt, 16'd0);
    repeat (3) idle(1'b0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic        r;
      logic        v;
      logic        st;
      logic [10:0] a;
      logic [3:0]  rp;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 2) != 0);
      st = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 3) == 0) ? 11'h7F8 + 11'($urandom_range(0, 7))
                                       : 11'($urandom);
      rp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      step(r, v, 2'($urandom), 1'($urandom), a, rp, st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/green_ins_enc.md
# green_ins_enc

Instruction encoder/issuer for the green datapath. It accepts high-level register commands over a valid/ready handshake and emits 16-bit instruction words onto the instruction bus feeding the green decoder. The decoder drives RA/RB load, increment and store-enable from those words. Each command can be repeated, and store commands auto-walk their address. Idle cycles always carry a no-op word, so the decoder never acts on stale data.

## Interface
- REP_W, default 4: width of the repeat field; one command issues cmd_rep+1 words (max 2^REP_W).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  2  0=load, 1=store, 2=increment, 3=no-op.
- cmd_sel  in  1  register select: 0=RA, 1=RB (ignored for store/no-op; encoded as given).
- cmd_arg  in  11  operand field, placed in ins_out[10:0].
- cmd_rep  in  REP_W  extra repeats (0 = single word).
- ins_out  out  16  instruction word to decoder.
- ins_valid  out  1  ins_out holds a real word.
- ins_stall  in  1  sink cannot accept the current word.
- busy  out  1  command in progress (state ISSUE).
- issued_cnt  out  16  count of words accepted by the sink.

## Operation
- Encoding: ins_out[15:12]=opcode (load 4'b0000, store 4'b0001, inc 4'b0010, no-op 4'b1111); ins_out[11]=cmd_sel; ins_out[10:0]=arg.
- Idle word: whenever ins_valid=0, ins_out=16'hF000. The opcode 4'b1111 leaves the decoder's RA/RB unchanged and WE=0.
- Word acceptance: a word is consumed on any cycle with ins_valid=1 and ins_stall=0.
- FSM states: IDLE and ISSUE.
  - IDLE: cmd_ready=1, ins_valid=0. On cmd_valid&&cmd_ready, latch op/sel/arg and rem=cmd_rep, then go to ISSUE.
  - ISSUE: ins_valid=1 and ins_out=encoded word.
    - Stalled cycle: all state and ins_out hold.
    - Consume with rem>0: rem decrements. For store only, arg increments modulo 2^11 (0x7FF wraps to 0x000). Load, inc and no-op keep arg constant.
    - Consume with rem==0: the command completes. If cmd_valid is high the same cycle, the next command is latched and the FSM stays in ISSUE; otherwise it goes to IDLE.
- cmd_ready = (state==IDLE) || (state==ISSUE && rem==0 && !ins_stall). It is combinational on ins_stall.
- cmd_ignored fields: ins_stall is ignored while ins_valid=0.
- issued_cnt increments by 1 per consumed word and wraps 0xFFFF to 0x0000. No-op words count.
- busy = (state==ISSUE).
- Reset (any state, including mid-command): the FSM goes to IDLE, and remaining repeats and the latched command are discarded.

## Timing
- Reset values: ins_out=16'hF000, ins_valid=0, cmd_ready=1, busy=0, issued_cnt=0, rem=0.
- Latency: a command accepted at edge T shows its first word on ins_out/ins_valid in cycle T+1.
- Throughput: with no stalls, a command produces cmd_rep+1 words in cmd_rep+1 consecutive cycles.
- Back-to-back commands issue with no bubble: the first word of command N+1 follows the last word of command N directly.
- Stall: each stalled cycle extends the command by exactly one cycle. ins_out is stable throughout the stall.
- All outputs are registered except cmd_ready.

## Test plan
1. Reset: assert rst for 2 cycles -> ins_out=0xF000, ins_valid=0, cmd_ready=1, busy=0, issued_cnt=0.
2. Load RA with arg 0x123, rep 0, no stall -> next cycle ins_out=0x0123 with ins_valid=1 for exactly one cycle; then ins_out=0xF000, issued_cnt=1, cmd_ready=1.
3. Increment RB, rep 3 -> four consecutive words of 0x2800; busy high for 4 cycles; issued_cnt=4.
4. Store with arg 0x7FE, rep 2, ins_stall high for 2 cycles while the second word is presented -> words are 0x17FE, then 0x17FF held for 3 cycles, then 0x1000; cmd_ready stays low until the final word is consumed; issued_cnt=3.
5. Back-to-back: a second command (inc RA, arg 0) is held valid during the last word of a load-RB command (arg 0x005) -> ins_out=0x0805 is followed immediately by 0x2000 with no 0xF000 gap; cmd_ready is high in that boundary cycle.
6. Reset mid-operation: a no-op command with rep 7 has rst asserted after 3 words are consumed -> the next cycle shows ins_out=0xF000, ins_valid=0, busy=0, issued_cnt=0, and no further words are emitted.
